// File: rtl/wb_pkg.sv
// Shared Wishbone constants and the burst master's FSM encoding.
package wb_pkg;

  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] END     = 3'b111;

  localparam logic [1:0] LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } dma_state_t;

endpackage

// File: rtl/wb_burst_len_calc.sv
// Beats in the next burst: the remaining count, clipped so the burst stops at
// the next MAX_BURST-aligned address boundary.
module wb_burst_len_calc #(
  parameter int Aw        = 10,
  parameter int LENw      = 8,
  parameter int MAX_BURST = 16
) (
  input  logic [LENw-1:0] remaining_i,
  input  logic [Aw-1:0]   addr_i,
  output logic [LENw:0]   beats_o
);

  localparam int CW = LENw + 1;

  logic [Aw-1:0] offs;
  logic [CW-1:0] room;
  logic [CW-1:0] rem_ext;

  // MAX_BURST is a power of two, so the modulo is a mask.
  always_comb begin
    offs    = addr_i & Aw'(MAX_BURST - 1);
    room    = CW'(MAX_BURST) - CW'(offs);
    rem_ext = {1'b0, remaining_i};
    beats_o = (rem_ext < room) ? rem_ext : room;
  end

endmodule

// File: rtl/wb_burst_dma_master.sv
// Wishbone burst master: splits one (addr, len, dir) command into incrementing
// bursts that never cross a MAX_BURST-aligned boundary.
module wb_burst_dma_master
  import wb_pkg::*;
#(
  parameter int Dw        = 32,
  parameter int Aw        = 10,
  parameter int SELw      = Dw / 8,
  parameter int CTIw      = 3,
  parameter int BTEw      = 2,
  parameter int LENw      = 8,
  parameter int MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [Aw-1:0]   cmd_addr,
  input  logic [LENw-1:0] cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [Dw-1:0]   wr_data,
  output logic            rd_valid,
  output logic [Dw-1:0]   rd_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [Aw-1:0]   m_addr_o,
  output logic [Dw-1:0]   m_dat_o,
  output logic [SELw-1:0] m_sel_o,
  output logic [CTIw-1:0] m_cti_o,
  output logic [BTEw-1:0] m_bte_o,
  output logic            m_stb_o,
  output logic            m_cyc_o,
  output logic            m_we_o,
  input  logic [Dw-1:0]   m_dat_i,
  input  logic            m_ack_i,
  input  logic            m_err_i,
  input  logic            m_rty_i,
  output logic [1:0]      dbg_state_o
);

  // Handshakes: a command moves on a cycle with cmd_valid & cmd_ready; a write
  // beat moves on a cycle with wr_valid & wr_ready (wr_ready only pulses with
  // the slave ack); rd_valid is a one-cycle push with no backpressure.

  dma_state_t      state_q, state_d;
  logic            we_q, we_d;
  logic [Aw-1:0]   addr_q, addr_d;
  logic [LENw-1:0] rem_q, rem_d;
  logic [LENw:0]   left_q, left_d;
  logic            single_q, single_d;
  logic            err_q, err_d;

  logic [LENw-1:0] calc_rem;
  logic [Aw-1:0]   calc_addr;
  logic [LENw:0]   calc_beats;
  logic            cyc, stb, abort, beat_ok;
  logic [2:0]      cti;

  wb_burst_len_calc #(
    .Aw       (Aw),
    .LENw     (LENw),
    .MAX_BURST(MAX_BURST)
  ) u_len_calc (
    .remaining_i(calc_rem),
    .addr_i     (calc_addr),
    .beats_o    (calc_beats)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      left_q   <= '0;
      single_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      left_q   <= left_d;
      single_q <= single_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    left_d   = left_q;
    single_d = single_q;
    err_d    = err_q;

    // In IDLE the calculator sizes the first burst straight from the command.
    calc_rem  = (state_q == ST_IDLE) ? cmd_len : rem_q;
    calc_addr = (state_q == ST_IDLE) ? cmd_addr : addr_q;

    cyc     = (state_q == ST_BUS);
    stb     = cyc & (~we_q | wr_valid);
    abort   = stb & (m_err_i | m_rty_i);
    beat_ok = stb & m_ack_i & ~abort;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          we_d     = cmd_we;
          addr_d   = cmd_addr;
          rem_d    = cmd_len;
          err_d    = 1'b0;
          left_d   = calc_beats;
          single_d = (calc_beats == (LENw+1)'(1));
          state_d  = (cmd_len == '0) ? ST_DONE : ST_BUS;
        end
      end
      ST_BUS: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (beat_ok) begin
          addr_d = addr_q + Aw'(1);
          rem_d  = rem_q - LENw'(1);
          left_d = left_q - (LENw+1)'(1);
          if (left_q == (LENw+1)'(1)) begin
            state_d = (rem_q == LENw'(1)) ? ST_DONE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        left_d   = calc_beats;
        single_d = (calc_beats == (LENw+1)'(1));
        state_d  = ST_BUS;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (!cyc)                           cti = CLASSIC;
    else if (single_q)                  cti = CLASSIC;
    else if (left_q == (LENw+1)'(1))    cti = END;
    else                                cti = INCR;
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err         = done & err_q;
  assign wr_ready    = beat_ok & we_q;
  assign rd_valid    = beat_ok & ~we_q;
  assign rd_data     = m_dat_i;
  assign m_addr_o    = addr_q;
  assign m_dat_o     = (cyc & we_q) ? wr_data : '0;
  assign m_sel_o     = '1;
  assign m_cti_o     = CTIw'(cti);
  assign m_bte_o     = BTEw'(LINEAR);
  assign m_stb_o     = stb;
  assign m_cyc_o     = cyc;
  assign m_we_o      = cyc & we_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_burst_dma_master.sv
// Scoreboard bench for wb_burst_dma_master: a burst-splitting reference model
// fills expected queues, a Wishbone slave model responds, a monitor checks.
module tb_wb_burst_dma_master;

  localparam int Dw = 32;
  localparam int Aw = 10;
  localparam int LENw = 8;
  localparam int MB = 16;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [Aw-1:0]   cmd_addr;
  logic [LENw-1:0] cmd_len;
  logic            wr_valid, wr_ready;
  logic [Dw-1:0]   wr_data;
  logic            rd_valid;
  logic [Dw-1:0]   rd_data;
  logic            busy, done, err;
  logic [Aw-1:0]   m_addr_o;
  logic [Dw-1:0]   m_dat_o, m_dat_i;
  logic [3:0]      m_sel_o;
  logic [2:0]      m_cti_o;
  logic [1:0]      m_bte_o;
  logic            m_stb_o, m_cyc_o, m_we_o;
  logic            m_ack_i, m_err_i, m_rty_i;
  logic [1:0]      dbg_state_o;

  wb_burst_dma_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .m_addr_o(m_addr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
    .m_cti_o(m_cti_o), .m_bte_o(m_bte_o), .m_stb_o(m_stb_o),
    .m_cyc_o(m_cyc_o), .m_we_o(m_we_o), .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
    .dbg_state_o(dbg_state_o)
  );

  typedef struct packed {
    logic [Aw-1:0] addr;
    logic [2:0]    cti;
    logic          we;
    logic [Dw-1:0] dat;
    logic          new_burst;
    logic          first;
    logic          last;
  } beat_t;
  localparam int BEAT_W = $bits(beat_t);

  logic [BEAT_W-1:0] exp_q[$];
  logic [8:0]        exp_done_q[$];
  logic [Dw-1:0]     wr_src_q[$];
  logic [Dw-1:0]     slave_mem[DEPTH];
  logic [Dw-1:0]     ref_mem[DEPTH];

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Wishbone slave model ----------------
  int wait_pct = 0;
  int abort_at = 0;
  bit abort_rty = 1'b0;
  int beat_idx = 0;

  initial begin
    m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0; m_dat_i = '0;
    forever begin
      @(negedge clk);
      m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0; m_dat_i = $urandom;
      if (m_cyc_o && m_stb_o) begin
        if (abort_at != 0 && beat_idx + 1 == abort_at) begin
          if (abort_rty) m_rty_i = 1'b1;
          else           m_err_i = 1'b1;
        end else if ($urandom_range(0, 99) >= wait_pct) begin
          m_ack_i = 1'b1;
          if (m_we_o) slave_mem[m_addr_o] = m_dat_o;
          else        m_dat_i = slave_mem[m_addr_o];
        end
      end
    end
  end

  // ---------------- Write data source ----------------
  int wr_gap_pct = 0;
  int wr_pause_at = -1;
  int wr_pause_left = 0;
  int wr_sent = 0;

  initial begin
    bit fire;
    wr_valid = 1'b0; wr_data = '0;
    forever begin
      @(negedge clk); #3;
      fire = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (fire && wr_src_q.size() > 0) begin
        void'(wr_src_q.pop_front());
        wr_sent++;
      end
      if (wr_src_q.size() == 0) wr_valid = 1'b0;
      else if (wr_sent == wr_pause_at && wr_pause_left > 0) begin
        wr_valid = 1'b0;
        wr_pause_left--;
      end else wr_valid = ($urandom_range(0, 99) >= wr_gap_pct);
      wr_data = (wr_src_q.size() > 0) ? wr_src_q[0] : '0;
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  bit mon_en = 1'b0;
  bit done_due = 1'b0, ready_due = 1'b0, err_prev = 1'b0, cyc_prev = 1'b0;
  int low_cnt = 0, last_low = 0, data_cnt = 0;
  int stall_cnt = 0, cyc_cnt = 0, done_cnt = 0;

  initial begin
    beat_t      b;
    logic [8:0] e;
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        if (done_due)  chk("done_after_last", done, 1);
        if (ready_due) chk("cmd_ready_after_done", cmd_ready, 1);
        if (err_prev)  chk("cyc_drop_after_abort", m_cyc_o, 0);
        done_due = 1'b0; ready_due = 1'b0; err_prev = 1'b0;

        if (m_cyc_o) begin
          chk("busy_with_cyc", busy, 1);
          cyc_cnt++;
          if (!m_stb_o) stall_cnt++;
          if (!cyc_prev) last_low = low_cnt;
          low_cnt = 0;
        end else low_cnt++;
        cyc_prev = m_cyc_o;

        if (cmd_valid && cmd_ready) begin
          data_cnt = 0;
          if (cmd_len == '0) done_due = 1'b1;
        end

        if (m_cyc_o && m_stb_o && m_ack_i && !m_err_i && !m_rty_i) begin
          if (exp_q.size() == 0) chk("unexpected_beat", m_addr_o, 'x);
          else begin
            b = beat_t'(exp_q.pop_front());
            chk("beat_addr", m_addr_o, b.addr);
            chk("beat_cti", m_cti_o, b.cti);
            chk("beat_we", m_we_o, b.we);
            if (b.we) begin
              chk("beat_wdata", m_dat_o, b.dat);
              chk("wr_ready_on_ack", wr_ready, 1);
            end else begin
              chk("rd_valid_on_ack", rd_valid, 1);
              chk("rd_data", rd_data, b.dat);
            end
            if (b.new_burst && !b.first) chk("gap_cycles", last_low, 1);
            if (b.last) done_due = 1'b1;
          end
          data_cnt++;
          beat_idx++;
        end else begin
          chk("rd_valid_idle", rd_valid, 0);
          chk("wr_ready_idle", wr_ready, 0);
        end

        if (m_cyc_o && m_stb_o && (m_err_i || m_rty_i)) err_prev = 1'b1;

        if (done) begin
          done_cnt++;
          if (exp_done_q.size() == 0) chk("unexpected_done", done, 0);
          else begin
            e = exp_done_q.pop_front();
            chk("done_err", err, e[8]);
            chk("done_beats", data_cnt, e[7:0]);
          end
          ready_due = 1'b1;
        end else chk("err_without_done", err, 0);
      end
    end
  end

  // ---------------- Driver with reference model ----------------
  task automatic issue_cmd(input bit we, input int addr, input int len, input int abort_beat,
                           input bit use_rty, input bit use_dbase, input logic [Dw-1:0] dbase,
                           input bit wait_done);
    int a, r, k, bl, counted, t, d0;
    logic [Dw-1:0] d;
    beat_t bt;
    d0 = done_cnt;
    a = addr; r = len; k = 0;
    counted = (abort_beat > 0 && abort_beat <= len) ? abort_beat - 1 : len;
    wr_sent = 0;
    while (r > 0) begin
      bl = MB - (a % MB);
      if (r < bl) bl = r;
      for (int i = 0; i < bl; i++) begin
        d = use_dbase ? dbase + Dw'(k) : Dw'($urandom);
        if (we) wr_src_q.push_back(d);
        if (k < counted) begin
          if (we) ref_mem[a] = d;
          bt.addr = Aw'(a);
          bt.cti = (bl == 1) ? 3'b000 : ((i == bl - 1) ? 3'b111 : 3'b010);
          bt.we = we;
          bt.dat = we ? d : ref_mem[a];
          bt.new_burst = (i == 0);
          bt.first = (k == 0);
          bt.last = (k == len - 1);
          exp_q.push_back(bt);
        end
        a = (a + 1) % DEPTH;
        k++;
      end
      r -= bl;
    end
    exp_done_q.push_back({(abort_beat > 0 && abort_beat <= len), 8'(counted)});
    abort_at = (abort_beat > 0 && abort_beat <= len) ? abort_beat : 0;
    abort_rty = use_rty;
    beat_idx = 0;

    repeat (2) @(posedge clk);
    #1;
    cmd_we = we; cmd_addr = Aw'(addr); cmd_len = LENw'(len); cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 200) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (wait_done) begin
      t = 0;
      while (done_cnt == d0 && t < 3000) begin @(posedge clk); #1; t++; end
      chk("done_seen", (done_cnt != d0), 1);
      chk("beats_left_over", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      wr_src_q.delete();
      abort_at = 0;
    end
  endtask

  // ---------------- Test sequence ----------------
  initial begin
    int c0, t;
    reset = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slave_mem[i] = $urandom;
      ref_mem[i] = slave_mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cyc", m_cyc_o, 0);
    chk("rst_stb", m_stb_o, 0);
    chk("rst_we", m_we_o, 0);
    chk("rst_addr", m_addr_o, 0);
    chk("rst_cti", m_cti_o, 0);
    chk("rst_sel", m_sel_o, 4'hF);
    chk("rst_bte", m_bte_o, 0);
    chk("rst_dat_o", m_dat_o, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #2;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_cyc", m_cyc_o, 0);
    mon_en = 1'b1;

    // single-beat write
    issue_cmd(1'b1, 'h010, 1, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    chk("single_write_mem", slave_mem['h010], 32'hDEADBEEF);

    // read crossing a 16-word boundary: 4 + 16 beats
    issue_cmd(1'b0, 'h00C, 20, 0, 1'b0, 1'b0, '0, 1'b1);

    // write with a 3-cycle data stall after beat 3
    wr_pause_at = 3; wr_pause_left = 3; stall_cnt = 0;
    issue_cmd(1'b1, 'h020, 8, 0, 1'b0, 1'b1, 32'h1000_0000, 1'b1);
    chk("write_stall_cycles", stall_cnt, 3);
    for (int i = 0; i < 8; i++) chk("stalled_write_mem", slave_mem['h020 + i], 32'h1000_0000 + i);
    wr_pause_at = -1;

    // read aborted by err on beat 5
    issue_cmd(1'b0, 'h040, 16, 5, 1'b0, 1'b0, '0, 1'b1);

    // reset during beat 7 of a 16-beat read
    issue_cmd(1'b0, 'h100, 16, 0, 1'b0, 1'b0, '0, 1'b0);
    t = 0;
    while (beat_idx < 6 && t < 200) begin @(posedge clk); #1; t++; end
    chk("reached_beat7", beat_idx, 6);
    mon_en = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk); #2;
      chk("mid_rst_cyc", m_cyc_o, 0);
      chk("mid_rst_stb", m_stb_o, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_busy", busy, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete(); exp_done_q.delete(); wr_src_q.delete();
    done_due = 1'b0; ready_due = 1'b0; err_prev = 1'b0; cyc_prev = 1'b0; low_cnt = 0;
    @(negedge clk); #2;
    chk("after_rst_done", done, 0);
    chk("after_rst_cyc", m_cyc_o, 0);
    mon_en = 1'b1;

    // zero-length command
    c0 = cyc_cnt;
    issue_cmd(1'b0, 'h055, 0, 0, 1'b0, 1'b0, '0, 1'b1);
    chk("zero_len_no_cyc", cyc_cnt, c0);

    // randomized traffic: wait states, data gaps, aborts, address wrap
    for (int n = 0; n < 30; n++) begin
      bit we_r, rty_r;
      int addr_r, len_r, ab_r;
      we_r = 1'($urandom_range(0, 1));
      rty_r = 1'($urandom_range(0, 1));
      addr_r = $urandom_range(0, DEPTH - 1);
      len_r = $urandom_range(0, 40);
      ab_r = ($urandom_range(0, 7) == 0 && len_r > 0) ? $urandom_range(1, len_r) : 0;
      wait_pct = $urandom_range(0, 40);
      wr_gap_pct = $urandom_range(0, 40);
      issue_cmd(we_r, addr_r, len_r, ab_r, rty_r, 1'b0, '0, 1'b1);
    end
    wait_pct = 0; wr_gap_pct = 0;

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
